// File: rtl/fk_pkg.sv
// Shared definitions for the forward-kinematics sequencer.
// Holds the FSM state type, the result tags carried by the multiplier and
// adder tag pipes, the default operand width and two handy double constants.
package fk_pkg;

   localparam int unsigned FP_W_DEFAULT = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_MWAIT,
      S_ADD,
      S_AWAIT,
      S_DONE
   } fk_state_e;

   // Multiplier tags: index into the product register file
   localparam logic [1:0] TAG_L1C1  = 2'd0;
   localparam logic [1:0] TAG_L2C12 = 2'd1;
   localparam logic [1:0] TAG_L1S1  = 2'd2;
   localparam logic [1:0] TAG_L2S12 = 2'd3;

   // Adder tags
   localparam logic TAG_X = 1'b0;
   localparam logic TAG_Y = 1'b1;

   localparam logic [63:0] D_ZERO = 64'h0000_0000_0000_0000;
   localparam logic [63:0] D_ONE  = 64'h3FF0_0000_0000_0000;

endpackage

// File: rtl/fk_lat_tracker.sv
// Valid/tag shift pipe that follows an operation through a fixed-latency
// arithmetic unit. Whatever enters at an issue edge appears on out_valid /
// out_tag DEPTH edges later, aligned with the unit's result.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   flush        synchronous clear of every stage (discards in-flight ops)
//   in_valid     issue strobe
//   in_tag       tag travelling with the issue
//   out_valid    tag pipe output valid
//   out_tag      tag at the pipe output
module fk_lat_tracker #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned TAG_W = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag
);

   logic             vld [DEPTH];
   logic [TAG_W-1:0] tag [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            vld[i] <= 1'b0;
            tag[i] <= '0;
         end
      end else if (flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            vld[i] <= 1'b0;
            tag[i] <= '0;
         end
      end else begin
         vld[0] <= in_valid;
         tag[0] <= in_tag;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
            tag[i] <= tag[i-1];
         end
      end
   end

   assign out_valid = vld[DEPTH-1];
   assign out_tag   = tag[DEPTH-1];

endmodule

// File: rtl/fk_sequencer.sv
// Forward-kinematics sequencer: time-shares one pipelined multiplier and one
// pipelined adder to compute
//   x = l1*c1 + l2*c12,  y = l1*s1 + l2*s12
// No arithmetic happens here; operands and results pass through bit-exact.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start, abort          run request (IDLE only) / synchronous cancel
//   l1_d,l2_d,c1,s1,c12,s12  operands, latched when start is accepted
//   busy, done, x, y      status and results (x,y held until next done)
//   mul_a/b/en/aclr, mul_res  multiplier interface
//   add_a/b/en, add_res       adder interface
module fk_sequencer
   import fk_pkg::*;
#(
   parameter int unsigned FP_W    = FP_W_DEFAULT,
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned ADD_LAT = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [FP_W-1:0] l1_d,
   input  logic [FP_W-1:0] l2_d,
   input  logic [FP_W-1:0] c1,
   input  logic [FP_W-1:0] s1,
   input  logic [FP_W-1:0] c12,
   input  logic [FP_W-1:0] s12,
   output logic            busy,
   output logic            done,
   output logic [FP_W-1:0] x,
   output logic [FP_W-1:0] y,
   output logic [FP_W-1:0] mul_a,
   output logic [FP_W-1:0] mul_b,
   output logic            mul_en,
   output logic            mul_aclr,
   input  logic [FP_W-1:0] mul_res,
   output logic [FP_W-1:0] add_a,
   output logic [FP_W-1:0] add_b,
   output logic            add_en,
   input  logic [FP_W-1:0] add_res
);

   fk_state_e       state;
   logic [FP_W-1:0] l1_q, l2_q, c1_q, s1_q, c12_q, s12_q;
   logic [FP_W-1:0] prod [4];
   logic [FP_W-1:0] x_pend;    // x-sum waits here so x/y publish together
   logic [1:0]      mul_tag;
   logic            add_tag;
   logic            mv, av, atag;
   logic [1:0]      mtag;
   logic            flush;
   logic [1:0]      nxt_tag;
   logic [FP_W-1:0] nxt_a, nxt_b;

   assign flush = abort && (state != S_IDLE);

   // Operands for the next product issued while in MUL
   always_comb begin
      nxt_tag = mul_tag + 2'd1;
      nxt_a   = '0;
      nxt_b   = '0;
      case (nxt_tag)
         TAG_L2C12: begin nxt_a = l2_q; nxt_b = c12_q; end
         TAG_L1S1:  begin nxt_a = l1_q; nxt_b = s1_q;  end
         TAG_L2S12: begin nxt_a = l2_q; nxt_b = s12_q; end
         default:   begin nxt_a = l1_q; nxt_b = c1_q;  end
      endcase
   end

   fk_lat_tracker #(.DEPTH(MUL_LAT), .TAG_W(2)) u_mul_trk (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (mul_en),
      .in_tag    (mul_tag),
      .out_valid (mv),
      .out_tag   (mtag)
   );

   fk_lat_tracker #(.DEPTH(ADD_LAT), .TAG_W(1)) u_add_trk (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (add_en),
      .in_tag    (add_tag),
      .out_valid (av),
      .out_tag   (atag)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         x        <= '0;
         y        <= '0;
         mul_a    <= '0;
         mul_b    <= '0;
         mul_en   <= 1'b0;
         mul_aclr <= 1'b0;
         add_a    <= '0;
         add_b    <= '0;
         add_en   <= 1'b0;
         mul_tag  <= '0;
         add_tag  <= 1'b0;
         x_pend   <= '0;
         l1_q     <= '0;
         l2_q     <= '0;
         c1_q     <= '0;
         s1_q     <= '0;
         c12_q    <= '0;
         s12_q    <= '0;
         for (int unsigned i = 0; i < 4; i++) prod[i] <= '0;
      end else begin
         mul_aclr <= 1'b0;
         if (flush) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mul_en   <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            add_en   <= 1'b0;
            add_a    <= '0;
            add_b    <= '0;
            mul_aclr <= 1'b1;
         end else begin
            if (mv) prod[mtag] <= mul_res;
            case (state)
               S_IDLE: if (start) begin
                  l1_q    <= l1_d;
                  l2_q    <= l2_d;
                  c1_q    <= c1;
                  s1_q    <= s1;
                  c12_q   <= c12;
                  s12_q   <= s12;
                  busy    <= 1'b1;
                  mul_en  <= 1'b1;
                  mul_a   <= l1_d;
                  mul_b   <= c1;
                  mul_tag <= TAG_L1C1;
                  state   <= S_MUL;
               end
               S_MUL: begin
                  if (mul_tag == TAG_L2S12) begin
                     mul_en <= 1'b0;
                     mul_a  <= '0;
                     mul_b  <= '0;
                     state  <= S_MWAIT;
                  end else begin
                     mul_a   <= nxt_a;
                     mul_b   <= nxt_b;
                     mul_tag <= nxt_tag;
                  end
               end
               // Last product lands this edge; prod0/prod1 are long since stored
               S_MWAIT: if (mv && mtag == TAG_L2S12) begin
                  add_en  <= 1'b1;
                  add_a   <= prod[TAG_L1C1];
                  add_b   <= prod[TAG_L2C12];
                  add_tag <= TAG_X;
                  state   <= S_ADD;
               end
               S_ADD: begin
                  add_a   <= prod[TAG_L1S1];
                  add_b   <= prod[TAG_L2S12];
                  add_tag <= TAG_Y;
                  state   <= S_AWAIT;
               end
               S_AWAIT: begin
                  add_en <= 1'b0;
                  add_a  <= '0;
                  add_b  <= '0;
                  if (av && atag == TAG_X) x_pend <= add_res;
                  if (av && atag == TAG_Y) begin
                     x     <= x_pend;
                     y     <= add_res;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
               S_DONE: begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
